// File: rtl/neuron_layer_stage.sv
// neuron_layer_stage: fully-connected layer stage with broadcast MAC lanes,
// per-neuron bias, linear/ReLU activation and a serialised result stream.
module neuron_layer_stage #(
  parameter int NUM_NEURONS = 8,
  parameter int VEC_LEN     = 16,
  parameter int DATA_W      = 16,
  parameter int FRAC        = 8,
  parameter int ACC_W       = 2*DATA_W+$clog2(VEC_LEN)+1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [NUM_NEURONS*DATA_W-1:0] tap_in,
  input  logic [NUM_NEURONS*DATA_W-1:0] bias_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [DATA_W-1:0]             out_pre,
  output logic                          out_last
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN-1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idxNext;

  logic signed [ACC_W-1:0]    acc     [NUM_NEURONS];
  logic signed [ACC_W-1:0]    accNext [NUM_NEURONS];
  logic signed [ACC_W-1:0]    base    [NUM_NEURONS];
  logic signed [ACC_W-1:0]    biasExt [NUM_NEURONS];
  logic signed [ACC_W-1:0]    shifted [NUM_NEURONS];
  logic signed [2*DATA_W-1:0] tapExt  [NUM_NEURONS];
  logic signed [2*DATA_W-1:0] prod    [NUM_NEURONS];
  logic signed [DATA_W-1:0]   preNew  [NUM_NEURONS];
  logic signed [DATA_W-1:0]   actNew  [NUM_NEURONS];
  logic signed [DATA_W-1:0]   preBuf  [NUM_NEURONS];
  logic signed [DATA_W-1:0]   actBuf  [NUM_NEURONS];
  logic signed [2*DATA_W-1:0] sampleExt;

  logic accept;
  logic lastSample;
  logic load;
  logic lastOut;

  assign sampleExt  = {{DATA_W{in_data[DATA_W-1]}}, in_data};
  assign lastSample = (cnt == LAST_CNT);
  assign lastOut    = (state == DRAIN) && out_ready && (idx == LAST_IDX);
  assign in_ready   = !(lastSample && (state == DRAIN) && !lastOut);
  assign accept     = in_valid && in_ready;
  assign load       = accept && lastSample;
  assign idxNext    = idx + 1'b1;

  // Per-lane MAC update, then rescale, saturate and activate the result.
  always_comb begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      tapExt[k] = {{DATA_W{tap_in[k*DATA_W+DATA_W-1]}},
                   tap_in[k*DATA_W +: DATA_W]};
      prod[k] = sampleExt * tapExt[k];
      biasExt[k] = {{(ACC_W-DATA_W){bias_in[k*DATA_W+DATA_W-1]}},
                    bias_in[k*DATA_W +: DATA_W]};
      base[k] = (cnt == '0) ? (biasExt[k] <<< FRAC) : acc[k];
      accNext[k] = base[k] +
        {{(ACC_W-2*DATA_W){prod[k][2*DATA_W-1]}}, prod[k]};
      shifted[k] = accNext[k] >>> FRAC;
      if (shifted[k] > SAT_MAX) begin
        preNew[k] = SAT_MAX[DATA_W-1:0];
      end else if (shifted[k] < SAT_MIN) begin
        preNew[k] = SAT_MIN[DATA_W-1:0];
      end else begin
        preNew[k] = shifted[k][DATA_W-1:0];
      end
      actNew[k] = (mode && preNew[k][DATA_W-1]) ? '0 : preNew[k];
    end
  end

  // Sample counter and accumulators advance only on accepted samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      for (int k = 0; k < NUM_NEURONS; k++) acc[k] <= '0;
    end else if (accept) begin
      cnt <= lastSample ? '0 : cnt + 1'b1;
      for (int k = 0; k < NUM_NEURONS; k++) acc[k] <= accNext[k];
    end
  end

  // Output FSM: load the buffer at vector end, then drain one neuron per handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pre   <= '0;
      out_last  <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        preBuf[k] <= '0;
        actBuf[k] <= '0;
      end
    end else if (load) begin
      state     <= DRAIN;
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= actNew[0];
      out_pre   <= preNew[0];
      out_last  <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        preBuf[k] <= preNew[k];
        actBuf[k] <= actNew[k];
      end
    end else if (state == DRAIN && out_ready) begin
      if (idx == LAST_IDX) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        idx      <= idxNext;
        out_data <= actBuf[idxNext];
        out_pre  <= preBuf[idxNext];
        out_last <= (idxNext == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_neuron_layer_stage.sv
// tb_neuron_layer_stage: scoreboard bench for neuron_layer_stage
// with directed vectors, backpressure, bubbles, reset and random traffic.
module tb_neuron_layer_stage;

  localparam int NN = 4;
  localparam int VL = 3;
  localparam int DW = 16;
  localparam int FR = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [NN*DW-1:0] tap_in = '0;
  logic [NN*DW-1:0] bias_in = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [DW-1:0] out_pre;
  logic out_last;

  typedef struct {
    int data;
    int pre;
    bit last;
  } exp_t;

  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int rxCount = 0;

  neuron_layer_stage #(
    .NUM_NEURONS(NN),
    .VEC_LEN(VL),
    .DATA_W(DW),
    .FRAC(FR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .tap_in(tap_in),
    .bias_in(bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pre(out_pre),
    .out_last(out_last)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic pushExp(input int d, input int p, input bit l);
    exp_t e;
    e.data = d;
    e.pre  = p;
    e.last = l;
    expQ.push_back(e);
  endtask

  // Reference: exact integer dot product, floor-divide by 2^FRAC, clamp, ReLU.
  task automatic modelVec(input int xs[VL], input int taps[NN],
                          input int bias[NN], input bit m);
    longint a;
    longint fl;
    int p;
    for (int k = 0; k < NN; k++) begin
      a = longint'(bias[k]) * 256;
      for (int i = 0; i < VL; i++) a += longint'(xs[i]) * longint'(taps[k]);
      fl = a / 256;
      if (a < 0 && (a % 256) != 0) fl -= 1;
      if (fl > 32767) p = 32767;
      else if (fl < -32768) p = -32768;
      else p = int'(fl);
      pushExp((m && p < 0) ? 0 : p, p, k == NN-1);
    end
  endtask

  task automatic sendSample(input int x, input int taps[NN], input int bias[NN],
                            input bit first, input bit bub);
    int w;
    int g;
    w = 0;
    if (bub) begin
      g = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data = x[DW-1:0];
    for (int k = 0; k < NN; k++) begin
      tap_in[k*DW +: DW] = taps[k][DW-1:0];
      bias_in[k*DW +: DW] = first ? bias[k][DW-1:0] : DW'($urandom);
    end
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendVector(input int xs[VL], input int taps[NN], input int bias[NN],
                            input bit m, input bit bub, input bit useModel);
    mode = m;
    if (useModel) modelVec(xs, taps, bias, m);
    for (int i = 0; i < VL; i++) sendSample(xs[i], taps, bias, i == 0, bub);
  endtask

  task automatic waitEmpty();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 1000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expQ.size());
    end
  endtask

  function automatic int rnd(input bit big);
    if (big) return int'($signed(DW'($urandom)));
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  initial begin
    exp_t e;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL unexpected_output: got %0d expected none",
                       $signed(out_data));
            end else begin
              e = expQ.pop_front();
              chk("out_data", longint'($signed(out_data)), e.data);
              chk("out_pre", longint'($signed(out_pre)), e.pre);
              chk("out_last", out_last, e.last);
            end
            rxCount++;
          end
        end
      end
      begin : watchdog
        repeat (40000) @(posedge clk);
        mismatched++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
      begin : stim
        int xs[VL];
        int taps[NN];
        int bias[NN];
        int base;
        int w;
        bit doneR;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_pre", out_pre, 0);
        chk("rst_out_last", out_last, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // basic
        xs = '{256, 256, 256};
        taps = '{256, 256, 256, 256};
        bias = '{0, 0, 0, 0};
        for (int k = 0; k < NN; k++) pushExp(768, 768, k == NN-1);
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b0);
        chk("latency_out_valid", out_valid, 1);
        waitEmpty();

        // bias, linear then ReLU back-to-back
        taps = '{-256, 256, -256, 256};
        bias = '{128, 128, 128, 128};
        pushExp(-640, -640, 0); pushExp(896, 896, 0);
        pushExp(-640, -640, 0); pushExp(896, 896, 1);
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b0);
        pushExp(0, -640, 0); pushExp(896, 896, 0);
        pushExp(0, -640, 0); pushExp(896, 896, 1);
        sendVector(xs, taps, bias, 1'b1, 1'b0, 1'b0);
        waitEmpty();

        // saturation both ways
        xs = '{32767, 32767, 32767};
        taps = '{32767, 32767, 32767, 32767};
        bias = '{32767, 32767, 32767, 32767};
        for (int k = 0; k < NN; k++) pushExp(32767, 32767, k == NN-1);
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b0);
        taps = '{-32767, -32767, -32767, -32767};
        for (int k = 0; k < NN; k++) pushExp(-32768, -32768, k == NN-1);
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b0);
        waitEmpty();

        // backpressure while a second vector streams in
        base = rxCount;
        bias = '{3, -5, 0, 100};
        fork
          begin
            xs = '{256, 256, 256};
            taps = '{256, 256, 256, 256};
            sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b1);
            xs = '{256, 512, -256};
            taps = '{100, -300, 700, 256};
            sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b1);
          end
          begin
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 100) begin
              w++;
              @(negedge clk);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
            chk("bp_in_valid_held", in_valid, 1);
            chk("bp_in_ready_stall", in_ready, 0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
          end
        join
        waitEmpty();
        repeat (3) @(posedge clk);
        #1;
        chk("bp_result_count", rxCount - base, 8);

        // bubbles
        xs = '{256, 256, 256};
        taps = '{256, 256, 256, 256};
        bias = '{0, 0, 0, 0};
        for (int k = 0; k < NN; k++) pushExp(768, 768, k == NN-1);
        sendVector(xs, taps, bias, 1'b0, 1'b1, 1'b0);
        waitEmpty();

        // reset mid-drain
        base = rxCount;
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b1);
        w = 0;
        while (rxCount < base + 2 && w < 100) begin
          @(negedge clk);
          #1;
          w++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_results", rxCount - base, 2);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        base = rxCount;
        sendVector(xs, taps, bias, 1'b0, 1'b0, 1'b1);
        waitEmpty();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_recover_count", rxCount - base, 4);

        // random traffic with random backpressure
        doneR = 1'b0;
        fork
          begin
            for (int v = 0; v < 24; v++) begin
              for (int i = 0; i < VL; i++) xs[i] = rnd(v % 4 == 3);
              for (int k = 0; k < NN; k++) begin
                taps[k] = rnd(v % 4 == 3);
                bias[k] = rnd(v % 5 == 4);
              end
              sendVector(xs, taps, bias, 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b1);
            end
            doneR = 1'b1;
          end
          begin
            while (!doneR) begin
              @(posedge clk);
              #1;
              out_ready = ($urandom_range(0, 3) != 0);
            end
          end
        join
        out_ready = 1'b1;
        waitEmpty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
    join
  end

endmodule
